// File: rtl/decode_stage_pkg.sv
// Shared MIPS opcode constants, extender select codes and decoded-beat types
// for decode_stage and its instr_decode sub-module.
package decode_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] EXT_OP_SE = 2'd0;
  localparam logic [1:0] EXT_OP_ZE = 2'd1;
  localparam logic [1:0] EXT_OP_LS = 2'd2;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] im;
    logic [1:0]  ext_op;
    logic [25:0] jaddr;
    logic        illegal;
  } dec_t;

  typedef struct packed {
    logic [31:0] pc;
    dec_t        dec;
  } beat_t;

  localparam int DEC_W = $bits(dec_t);

endpackage

// File: rtl/decode_stage_instr_decode.sv
// Purely combinational MIPS field extraction, extender select and
// supported-opcode check.
module instr_decode
  import decode_stage_pkg::*;
(
  input  logic [31:0]      instr_i,
  output logic [DEC_W-1:0] dec_o
);

  dec_t dec;

  always_comb begin
    dec         = '0;
    dec.op      = instr_i[31:26];
    dec.rs      = instr_i[25:21];
    dec.rt      = instr_i[20:16];
    dec.rd      = instr_i[15:11];
    dec.shamt   = instr_i[10:6];
    dec.funct   = instr_i[5:0];
    dec.im      = instr_i[15:0];
    dec.jaddr   = instr_i[25:0];

    // Logical immediates zero-extend, lui shifts; everything else sign-extends.
    case (dec.op)
      OP_ANDI, OP_ORI, OP_XORI: dec.ext_op = EXT_OP_ZE;
      OP_LUI:                   dec.ext_op = EXT_OP_LS;
      default:                  dec.ext_op = EXT_OP_SE;
    endcase

    case (dec.op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_LW, OP_SW: dec.illegal = 1'b0;
      default:      dec.illegal = 1'b1;
    endcase
  end

  assign dec_o = dec;

endmodule

// File: rtl/decode_stage.sv
// One-cycle pipelined MIPS decode stage. Define DECODE_SKID_EN to add a
// one-entry skid buffer so in_ready comes straight from a register.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [5:0]  out_op,
  output logic [5:0]  out_funct,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_shamt,
  output logic [15:0] out_im,
  output logic [1:0]  out_ext_op,
  output logic [25:0] out_jaddr,
  output logic        out_illegal
);

  // Handshake: a beat moves on any edge where valid && ready; a producer holds
  // valid and payload stable until that edge, and flush beats accept.
  logic [DEC_W-1:0] dec_raw;
  beat_t            in_beat;
  beat_t            out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             in_accept;

  instr_decode u_instr_decode (
    .instr_i (in_instr),
    .dec_o   (dec_raw)
  );

  assign in_beat = {in_pc, dec_raw};

`ifdef DECODE_SKID_EN
  beat_t skid_q, skid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  in_ready_q;

  assign in_ready  = in_ready_q;
  assign in_accept = in_valid && in_ready_q && !flush;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Skid entry is older than anything offered now, so it goes first.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_accept) begin
        out_d       = in_beat;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_accept) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end
`else
  assign in_ready  = !out_valid_q || out_ready;
  assign in_accept = in_valid && in_ready && !flush;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_accept) begin
      out_d       = in_beat;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end
`endif

  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_op      = out_q.dec.op;
  assign out_funct   = out_q.dec.funct;
  assign out_rs      = out_q.dec.rs;
  assign out_rt      = out_q.dec.rt;
  assign out_rd      = out_q.dec.rd;
  assign out_shamt   = out_q.dec.shamt;
  assign out_im      = out_q.dec.im;
  assign out_ext_op  = out_q.dec.ext_op;
  assign out_jaddr   = out_q.dec.jaddr;
  assign out_illegal = out_q.dec.illegal;

endmodule
